// File: rtl/multdiv_controller_pkg.sv
// multdiv_controller_pkg: shared constants and types for the multiply/divide
// sequencer (instruction field codes, register indices, exception codes,
// watchdog sizing, FSM state encoding).
package multdiv_controller_pkg;

  // Instruction decode fields
  localparam logic [4:0] OPC_RTYPE = 5'b00000;
  localparam logic [4:0] ALU_MULT  = 5'b00110;
  localparam logic [4:0] ALU_DIV   = 5'b00111;

  // Architectural register indices
  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam logic [4:0] REG_RSTATUS = 5'd30;
  localparam logic [4:0] REG_RA      = 5'd31;

  // Values written to $rstatus when the operation raises an exception
  localparam logic [31:0] EXC_MULT = 32'd4;
  localparam logic [31:0] EXC_DIV  = 32'd5;

  // Watchdog: maximum WAIT cycles before abort (legal 1..63)
  localparam int unsigned WD_W    = 6;
  localparam int unsigned TIMEOUT = 40;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_PEND  = 2'd3
  } state_e;

endpackage

// File: rtl/multdiv_controller_if.sv
// multdiv_controller_if: connection between the sequencer and the multdiv unit.
//   md_operandA/B : latched operands to the unit
//   ctrl_MULT/DIV : one-cycle start pulses
//   md_result     : unit result
//   md_exception  : overflow / divide-by-zero
//   md_resultRDY  : single-cycle result valid
// modport master = sequencer side, modport slave = multdiv unit side.
interface multdiv_controller_if;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;

  modport master (
    output md_operandA, md_operandB, ctrl_MULT, ctrl_DIV,
    input  md_result, md_exception, md_resultRDY
  );

  modport slave (
    input  md_operandA, md_operandB, ctrl_MULT, ctrl_DIV,
    output md_result, md_exception, md_resultRDY
  );
endinterface

// File: rtl/multdiv_controller_md_watchdog.sv
// multdiv_controller_md_watchdog: counts WAIT cycles and flags expiry.
// Used only when MULTDIV_TIMEOUT_EN is defined.
//   clock, reset : pipeline clock, synchronous active-high reset
//   clear        : zero the counter (asserted in the cycle before WAIT)
//   run          : controller is in WAIT this cycle
//   expired_c    : this is the TIMEOUT-th WAIT cycle with no result
module multdiv_controller_md_watchdog
  import multdiv_controller_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired_c
);

  logic [WD_W-1:0] count_q;
  logic [WD_W-1:0] count_d;

  // Counter next value
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = count_q + WD_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the number of WAIT cycles already completed
  assign expired_c = run && (count_q == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_controller.sv
// multdiv_controller: sequences multi-cycle MULT/DIV operations and arbitrates
// the single register-file write port between pipeline writeback and the
// multdiv result. Freezes the pipeline front while an operation is outstanding.
// Ports:
//   clock, reset          : pipeline clock, synchronous active-high reset
//   issue_valid, insn_x   : X-stage instruction and its valid
//   operandA, operandB    : X-stage source operands
//   md                    : multdiv unit connection (master side)
//   wb_we/wb_reg/wb_data  : pipeline writeback request
//   ctrl_writeEnable, ctrl_writeReg, data_writeReg : register-file write port
//   stall                 : freeze PC, F/D, D/X
//   md_retire             : one-cycle pulse in the commit cycle
//   busy                  : an operation is outstanding
// Optional feature macro: MULTDIV_TIMEOUT_EN (WAIT watchdog abort).
module multdiv_controller
  import multdiv_controller_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic [31:0]            insn_x,
  input  logic [31:0]            operandA,
  input  logic [31:0]            operandB,
  multdiv_controller_if.master   md,
  input  logic                   wb_we,
  input  logic [4:0]             wb_reg,
  input  logic [31:0]            wb_data,
  output logic                   ctrl_writeEnable,
  output logic [4:0]             ctrl_writeReg,
  output logic [31:0]            data_writeReg,
  output logic                   stall,
  output logic                   md_retire,
  output logic                   busy
);

  state_e      state_q, state_d;
  logic        is_div_q, is_div_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] res_q, res_d;
  logic        exc_q, exc_d;

  logic        md_op_c;
  logic        ctrl_mult_c;
  logic        ctrl_div_c;
  logic        wd_clear_c;
  logic        wd_run_c;
  logic        wd_expired_c;
  logic [4:0]  commit_reg_c;
  logic [31:0] commit_data_c;
  logic        unused_insn;

  // MULT/DIV decode
  assign md_op_c = (insn_x[31:27] == OPC_RTYPE) &&
                   ((insn_x[6:2] == ALU_MULT) || (insn_x[6:2] == ALU_DIV));
  assign unused_insn = ^{insn_x[21:7], insn_x[1:0]};

  // Exceptions redirect the commit to $rstatus with an op-specific code
  assign commit_reg_c  = exc_q ? REG_RSTATUS : rd_q;
  assign commit_data_c = exc_q ? (is_div_q ? EXC_DIV : EXC_MULT) : res_q;

`ifdef MULTDIV_TIMEOUT_EN
  multdiv_controller_md_watchdog u_md_watchdog (
    .clock     (clock),
    .reset     (reset),
    .clear     (wd_clear_c),
    .run       (wd_run_c),
    .expired_c (wd_expired_c)
  );
`else
  logic unused_wd;
  assign unused_wd    = wd_clear_c ^ wd_run_c;
  assign wd_expired_c = 1'b0;
`endif

  // Next-state, datapath capture and write-port arbitration
  always_comb begin
    state_d          = state_q;
    is_div_d         = is_div_q;
    rd_d             = rd_q;
    opa_d            = opa_q;
    opb_d            = opb_q;
    res_d            = res_q;
    exc_d            = exc_q;
    ctrl_mult_c      = 1'b0;
    ctrl_div_c       = 1'b0;
    wd_clear_c       = 1'b0;
    wd_run_c         = 1'b0;
    stall            = 1'b0;
    md_retire        = 1'b0;
    busy             = (state_q != ST_IDLE);
    ctrl_writeEnable = wb_we;
    ctrl_writeReg    = wb_reg;
    data_writeReg    = wb_data;

    unique case (state_q)
      ST_IDLE: begin
        if (issue_valid && md_op_c) begin
          is_div_d = (insn_x[6:2] == ALU_DIV);
          rd_d     = insn_x[26:22];
          opa_d    = operandA;
          opb_d    = operandB;
          stall    = 1'b1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        ctrl_mult_c = !is_div_q;
        ctrl_div_c  = is_div_q;
        wd_clear_c  = 1'b1;
        stall       = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        wd_run_c = 1'b1;
        stall    = 1'b1;
        if (md.md_resultRDY) begin
          res_d   = md.md_result;
          exc_d   = md.md_exception;
          state_d = ST_PEND;
        end else if (wd_expired_c) begin
          res_d   = '0;
          exc_d   = 1'b1;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        // Pipeline writeback has priority; the frozen front bounds the wait
        if (!wb_we) begin
          md_retire        = 1'b1;
          ctrl_writeEnable = (commit_reg_c != REG_ZERO);
          ctrl_writeReg    = commit_reg_c;
          data_writeReg    = commit_data_c;
          state_d          = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // All outputs are quiet while reset is held
    if (reset) begin
      ctrl_mult_c      = 1'b0;
      ctrl_div_c       = 1'b0;
      stall            = 1'b0;
      md_retire        = 1'b0;
      busy             = 1'b0;
      ctrl_writeEnable = 1'b0;
      ctrl_writeReg    = '0;
      data_writeReg    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      is_div_q <= 1'b0;
      rd_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      rd_q     <= rd_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      exc_q    <= exc_d;
    end
  end

  assign md.md_operandA = opa_q;
  assign md.md_operandB = opb_q;
  assign md.ctrl_MULT   = ctrl_mult_c;
  assign md.ctrl_DIV    = ctrl_div_c;

endmodule

// File: tb/tb_multdiv_controller.sv
// tb_multdiv_controller: randomized self-checking bench for multdiv_controller.
// The bench plays the multdiv unit and the pipeline; expected values come from
// the sequencing rules (issue/pulse/commit cycle offsets) and plain arithmetic.
module tb_multdiv_controller;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [31:0] insn_x;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        stall;
  logic        md_retire;
  logic        busy;

  int total = 0;
  int bad   = 0;

  multdiv_controller_if mdif ();

  multdiv_controller dut (
    .clock            (clk),
    .reset            (reset),
    .issue_valid      (issue_valid),
    .insn_x           (insn_x),
    .operandA         (operandA),
    .operandB         (operandB),
    .md               (mdif),
    .wb_we            (wb_we),
    .wb_reg           (wb_reg),
    .wb_data          (wb_data),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .stall            (stall),
    .md_retire        (md_retire),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_wb();
    wb_we   = 1'($urandom % 2);
    wb_reg  = 5'($urandom);
    wb_data = $urandom;
  endtask

  task automatic chk_pass(input string tag);
    check({tag, "_we"},  32'(ctrl_writeEnable), 32'(wb_we));
    check({tag, "_reg"}, 32'(ctrl_writeReg),    32'(wb_reg));
    check({tag, "_dat"}, data_writeReg,         wb_data);
  endtask

  function automatic logic [31:0] enc(input bit is_div, input logic [4:0] rd);
    logic [14:0] mid;
    logic [1:0]  lo;
    mid = 15'($urandom);
    lo  = 2'($urandom);
    return {5'b00000, rd, mid, (is_div ? 5'b00111 : 5'b00110), lo};
  endfunction

  function automatic logic [31:0] non_md_insn();
    logic [31:0] w;
    w = $urandom;
    if (w[31:27] == 5'b0 && (w[6:2] == 5'b00110 || w[6:2] == 5'b00111)) w[31] = 1'b1;
    return w;
  endfunction

  // Behaviour of the multdiv unit: signed 32-bit multiply/divide
  function automatic void ref_unit(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output bit exc);
    longint p;
    if (!is_div) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      res = p[31:0];
      exc = (p != longint'($signed(p[31:0])));
    end else if (b == 32'd0) begin
      res = 32'd0;
      exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
      res = a;
      exc = 1'b1;
    end else begin
      res = 32'($signed(a) / $signed(b));
      exc = 1'b0;
    end
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      issue_valid = 1'($urandom % 2);
      insn_x      = non_md_insn();
      mdif.md_resultRDY = 1'($urandom % 2);
      mdif.md_result    = $urandom;
      rand_wb();
      @(negedge clk);
      check("idle_stall", 32'(stall), 32'(0));
      check("idle_busy",  32'(busy), 32'(0));
      check("idle_ret",   32'(md_retire), 32'(0));
      check("idle_ctl",   32'({mdif.ctrl_MULT, mdif.ctrl_DIV}), 32'(0));
      chk_pass("idle");
      next_cycle();
    end
  endtask

  // Full MD transaction: issue, pulse, lat cycles to RDY, hold PEND cycles, commit
  task automatic run_md(input bit is_div, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input int hold,
                        input logic [4:0] hreg, input logic [31:0] hdata);
    logic [31:0] res, insn, dat;
    logic [4:0]  tgt;
    bit          exc;
    ref_unit(is_div, a, b, res, exc);
    insn = enc(is_div, rd);
    // issue cycle
    issue_valid = 1'b1; insn_x = insn; operandA = a; operandB = b;
    mdif.md_resultRDY = 1'b0; mdif.md_result = $urandom; mdif.md_exception = 1'b0;
    rand_wb();
    @(negedge clk);
    check("iss_stall", 32'(stall), 32'(1));
    check("iss_busy",  32'(busy), 32'(0));
    check("iss_ctl",   32'({mdif.ctrl_MULT, mdif.ctrl_DIV}), 32'(0));
    chk_pass("iss");
    next_cycle();
    // pulse cycle; a stray RDY here must be ignored
    operandA = $urandom; operandB = $urandom;
    mdif.md_resultRDY = 1'($urandom % 2); mdif.md_result = $urandom;
    mdif.md_exception = 1'($urandom % 2);
    rand_wb();
    @(negedge clk);
    check("st_mult",  32'(mdif.ctrl_MULT), 32'(!is_div));
    check("st_div",   32'(mdif.ctrl_DIV), 32'(is_div));
    check("st_opa",   mdif.md_operandA, a);
    check("st_opb",   mdif.md_operandB, b);
    check("st_stall", 32'(stall), 32'(1));
    check("st_busy",  32'(busy), 32'(1));
    chk_pass("st");
    next_cycle();
    mdif.md_resultRDY = 1'b0;
    for (int i = 1; i < lat; i++) begin
      mdif.md_result = $urandom;
      rand_wb();
      @(negedge clk);
      check("wt_stall", 32'(stall), 32'(1));
      check("wt_ctl",   32'({mdif.ctrl_MULT, mdif.ctrl_DIV}), 32'(0));
      check("wt_ret",   32'(md_retire), 32'(0));
      chk_pass("wt");
      next_cycle();
    end
    // result cycle
    mdif.md_resultRDY = 1'b1; mdif.md_result = res; mdif.md_exception = exc;
    rand_wb();
    @(negedge clk);
    check("rdy_stall", 32'(stall), 32'(1));
    check("rdy_ret",   32'(md_retire), 32'(0));
    chk_pass("rdy");
    next_cycle();
    mdif.md_resultRDY = 1'b0; mdif.md_result = $urandom; mdif.md_exception = 1'($urandom % 2);
    for (int i = 0; i < hold; i++) begin
      wb_we = 1'b1; wb_reg = hreg; wb_data = hdata;
      @(negedge clk);
      check("hold_stall", 32'(stall), 32'(1));
      check("hold_ret",   32'(md_retire), 32'(0));
      chk_pass("hold");
      next_cycle();
    end
    // commit cycle; X still shows the MD instruction
    wb_we = 1'b0; wb_reg = 5'($urandom); wb_data = $urandom;
    tgt = exc ? 5'd30 : rd;
    dat = exc ? (is_div ? 32'd5 : 32'd4) : res;
    @(negedge clk);
    check("cm_ret",   32'(md_retire), 32'(1));
    check("cm_stall", 32'(stall), 32'(0));
    check("cm_we",    32'(ctrl_writeEnable), 32'(tgt != 5'd0));
    check("cm_reg",   32'(ctrl_writeReg), 32'(tgt));
    check("cm_dat",   data_writeReg, dat);
    next_cycle();
    issue_valid = 1'b0;
  endtask

  task automatic run_reset_mid();
    issue_valid = 1'b1; insn_x = enc(1'b0, 5'd9); operandA = 32'd11; operandB = 32'd13;
    wb_we = 1'b0; mdif.md_resultRDY = 1'b0;
    for (int i = 0; i < 4; i++) next_cycle();  // issue, start, two WAIT cycles
    reset = 1'b1; wb_we = 1'b1; wb_reg = 5'd7; wb_data = 32'h1234;
    @(negedge clk);
    check("rst_in_we",    32'(ctrl_writeEnable), 32'(0));
    check("rst_in_stall", 32'(stall), 32'(0));
    next_cycle();
    reset = 1'b0; wb_we = 1'b0; wb_reg = 5'd0; wb_data = 32'd0; issue_valid = 1'b0;
    @(negedge clk);
    check("rst_busy",  32'(busy), 32'(0));
    check("rst_stall", 32'(stall), 32'(0));
    check("rst_ctl",   32'({mdif.ctrl_MULT, mdif.ctrl_DIV}), 32'(0));
    check("rst_opa",   mdif.md_operandA, 32'd0);
    check("rst_opb",   mdif.md_operandB, 32'd0);
    check("rst_we",    32'(ctrl_writeEnable), 32'(0));
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      mdif.md_resultRDY = 1'b1; mdif.md_result = 32'd143; mdif.md_exception = 1'b0;
      @(negedge clk);
      check("rst_late_we",  32'(ctrl_writeEnable), 32'(0));
      check("rst_late_ret", 32'(md_retire), 32'(0));
      check("rst_late_busy", 32'(busy), 32'(0));
      next_cycle();
    end
    mdif.md_resultRDY = 1'b0;
  endtask

  task automatic run_timeout();
    issue_valid = 1'b1; insn_x = enc(1'b0, 5'd7); operandA = 32'd3; operandB = 32'd5;
    wb_we = 1'b0; mdif.md_resultRDY = 1'b0;
    @(negedge clk);
    check("to_iss", 32'(stall), 32'(1));
    next_cycle();
`ifdef MULTDIV_TIMEOUT_EN
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      check("to_stall", 32'(stall), 32'(1));
      check("to_ret",   32'(md_retire), 32'(0));
      next_cycle();
    end
    @(negedge clk);
    check("to_cm_ret", 32'(md_retire), 32'(1));
    check("to_cm_we",  32'(ctrl_writeEnable), 32'(1));
    check("to_cm_reg", 32'(ctrl_writeReg), 32'(30));
    check("to_cm_dat", data_writeReg, 32'd4);
    next_cycle();
`else
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      check("nto_stall", 32'(stall), 32'(1));
      check("nto_busy",  32'(busy), 32'(1));
      next_cycle();
    end
    mdif.md_resultRDY = 1'b1; mdif.md_result = 32'd15; mdif.md_exception = 1'b0;
    @(negedge clk);
    check("nto_rdy_stall", 32'(stall), 32'(1));
    next_cycle();
    mdif.md_resultRDY = 1'b0;
    @(negedge clk);
    check("nto_cm_ret", 32'(md_retire), 32'(1));
    check("nto_cm_reg", 32'(ctrl_writeReg), 32'(7));
    check("nto_cm_dat", data_writeReg, 32'd15);
    next_cycle();
`endif
    issue_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b;
    reset = 1'b1; issue_valid = 1'b0; insn_x = '0; operandA = '0; operandB = '0;
    wb_we = 1'b0; wb_reg = '0; wb_data = '0;
    mdif.md_result = '0; mdif.md_exception = 1'b0; mdif.md_resultRDY = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      rand_wb();
      wb_we = 1'b1;
      @(negedge clk);
      check("por_we",    32'(ctrl_writeEnable), 32'(0));
      check("por_stall", 32'(stall), 32'(0));
      next_cycle();
    end
    reset = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    check("por_opa",  mdif.md_operandA, 32'd0);
    check("por_opb",  mdif.md_operandB, 32'd0);
    check("por_busy", 32'(busy), 32'(0));
    next_cycle();
    idle(5);

    run_md(1'b0, 5'd3, 32'd7, 32'd6, 17, 0, 5'd0, 32'd0);          // r3 = 42
    idle(2);
    run_md(1'b1, 5'd4, 32'd9, 32'd0, 5, 0, 5'd0, 32'd0);           // div by zero -> r30=5
    idle(1);
    run_md(1'b0, 5'd9, 32'd3, 32'd4, 3, 2, 5'd5, 32'h11);          // pipeline holds port 2 cycles
    run_md(1'b0, 5'd2, 32'd100, 32'hffff_fffd, 4, 0, 5'd0, 32'd0); // back-to-back
    run_md(1'b1, 5'd6, 32'd100, 32'd7, 6, 1, 5'd8, 32'h55);
    run_md(1'b0, 5'd0, 32'd5, 32'd5, 2, 0, 5'd0, 32'd0);           // r0 write suppressed
    run_md(1'b0, 5'd12, 32'h4000_0000, 32'd4, 1, 0, 5'd0, 32'd0);  // MULT overflow
    idle(3);

    for (int t = 0; t < 25; t++) begin
      if ($urandom % 2 == 0) begin
        a = $urandom_range(0, 2000) - 1000;
        b = $urandom_range(0, 40) - 20;
      end else begin
        a = $urandom;
        b = $urandom;
      end
      run_md(1'($urandom % 2), 5'($urandom), a, b, int'($urandom_range(1, 30)),
             int'($urandom_range(0, 2)), 5'($urandom), $urandom);
      idle(int'($urandom_range(0, 3)));
    end

    run_reset_mid();
    idle(2);
    run_timeout();
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
